// File: rtl/reg_writeback_queue_if.sv
// Producer and register-file handshake bundle for the writeback queue.
// The producer side drives in_*/wb_ready; the queue drives in_ready/wb_*.
interface reg_writeback_queue_if #(
  parameter int DW = 64
);
  logic          in_valid;
  logic          in_ready;
  logic [5:0]    in_opcode;
  logic [4:0]    in_rd;
  logic [DW-1:0] in_data;
  logic          wb_valid;
  logic          wb_ready;
  logic [4:0]    wb_rd;
  logic [DW-1:0] wb_data;

  modport master (
    output in_valid, in_opcode, in_rd, in_data, wb_ready,
    input  in_ready, wb_valid, wb_rd, wb_data
  );

  modport slave (
    input  in_valid, in_opcode, in_rd, in_data, wb_ready,
    output in_ready, wb_valid, wb_rd, wb_data
  );
endinterface

// File: rtl/reg_writeback_queue.sv
// Register-file writeback queue: formats results by opcode on entry, buffers
// them in a circular FIFO, drains one per cycle to the RF write port and
// flags read-after-write hazards against the decode source registers.
module reg_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int DW    = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  reg_writeback_queue_if.slave     bus,
  input  logic [4:0]               rs_i,
  input  logic [4:0]               rt_i,
  output logic                     hazard_rs_o,
  output logic                     hazard_rt_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     drop_pulse_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [4:0]    rd;
    logic [DW-1:0] data;
  } entry_t;

  entry_t            mem_q [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              drop_q, drop_d;

  logic [DW-1:0]     fmt_data;
  logic              fmt_ok;
  logic              accept, enq, deq;
  logic [DEPTH-1:0]  hit_rs, hit_rt;

  // Opcode-driven formatting; unknown opcodes are accepted but not stored.
  always_comb begin
    fmt_data = bus.in_data;
    fmt_ok   = 1'b1;
    case (bus.in_opcode)
      6'd34:                fmt_data = {{(DW-8){1'b0}}, bus.in_data[7:0]};
      6'd40:                fmt_data = {{(DW-16){1'b0}}, bus.in_data[15:0]};
      6'd42:                fmt_data = {{(DW-16){bus.in_data[15]}}, bus.in_data[15:0]};
      6'd32:                fmt_data = {{(DW-32){1'b0}}, bus.in_data[31:0]};
      6'd14, 6'd31, 6'd58:  fmt_data = bus.in_data;
      default:              fmt_ok   = 1'b0;
    endcase
  end

  // Full blocks acceptance outright, even if the head drains this cycle.
  assign bus.in_ready = (count_q != CW'(DEPTH));
  assign bus.wb_valid = (count_q != '0);
  assign accept       = bus.in_valid && bus.in_ready;
  assign enq          = accept && fmt_ok;
  assign deq          = bus.wb_valid && bus.wb_ready;

  // Head outputs are forced to zero when empty so stale storage never shows.
  assign bus.wb_rd   = bus.wb_valid ? mem_q[rd_ptr_q].rd   : '0;
  assign bus.wb_data = bus.wb_valid ? mem_q[rd_ptr_q].data : '0;
  assign count_o     = count_q;
  assign drop_pulse_o = drop_q;

  // Next-state for pointers, occupancy, per-entry valid bits and drop flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    drop_d   = accept && !fmt_ok;
    if (enq) begin
      wr_ptr_d          = wr_ptr_q + AW'(1);
      valid_d[wr_ptr_q] = 1'b1;
    end
    if (deq) begin
      rd_ptr_d          = rd_ptr_q + AW'(1);
      valid_d[rd_ptr_q] = 1'b0;
    end
    case ({enq, deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state with synchronous reset; a request in the reset cycle is lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      drop_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      drop_q   <= drop_d;
    end
  end

  // Entry payload storage; contents are qualified by valid_q, so no reset.
  always_ff @(posedge clk) begin
    if (rst_n && enq) mem_q[wr_ptr_q] <= '{rd: bus.in_rd, data: fmt_data};
  end

  // Per-entry source-register compare; the head still counts while draining.
  for (genvar i = 0; i < DEPTH; i++) begin : g_haz
    assign hit_rs[i] = valid_q[i] && (mem_q[i].rd == rs_i);
    assign hit_rt[i] = valid_q[i] && (mem_q[i].rd == rt_i);
  end

  assign hazard_rs_o = |hit_rs;
  assign hazard_rt_o = |hit_rt;
endmodule

// File: doc/reg_writeback_queue.md
# reg_writeback_queue

Write-side front end for the 32 x 64-bit general register file. Buffers completed ALU results and load data in a small FIFO and formats each entry by opcode (byte/halfword/word zero- or sign-extension). Drains entries one per cycle into the register file's single write port under a valid/ready handshake. Flags pending writes to the current source registers so decode can stall on read-after-write hazards.

## Interface
- DEPTH, 4, FIFO entries; power of two, minimum 2
- DW, 64, register data width
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk
- in_valid  in  1  producer presents a write request
- in_ready  out  1  queue can accept; equals !full
- in_opcode  in  6  primary opcode of the completing instruction
- in_rd  in  5  destination register index
- in_data  in  DW  raw result (ALU output or memory read data)
- wb_valid  out  1  head entry is presented to the register file; drives RegWrite
- wb_ready  in  1  register file accepts the write this cycle
- wb_rd  out  5  destination index of the head entry
- wb_data  out  DW  formatted data of the head entry
- rs, rt  in  5 each  source indices currently being read by decode
- hazard_rs, hazard_rt  out  1 each  a queued entry targets rs / rt
- count  out  $clog2(DEPTH)+1  current occupancy
- drop_pulse  out  1  one-cycle pulse when an accepted request is discarded

## Operation
- Accept when in_valid && in_ready. The opcode selects formatting, which is applied before storage:
  - 34: {56'b0, in_data[7:0]}
  - 40: {48'b0, in_data[15:0]}
  - 42: {{48{in_data[15]}}, in_data[15:0]}
  - 32: {32'b0, in_data[31:0]}
  - 14, 31, 58: in_data unchanged
- Any other opcode: the request is accepted and not enqueued. drop_pulse goes high the next cycle and count is unchanged.
- Storage is a circular buffer with read pointer, write pointer and occupancy counter. Pointers wrap modulo DEPTH.
- Output: wb_valid = (count != 0), with wb_rd/wb_data taken from the head entry. Dequeue happens when wb_valid && wb_ready.
- While wb_valid && !wb_ready, the head entry and its outputs hold stable.
- Simultaneous accept and dequeue: count is unchanged and both pointers advance.
- Full: in_ready = 0. There is no accept-while-full, even if a dequeue occurs in the same cycle.
- Writes to r0 are treated like any other index; no special casing.
- Hazard outputs are combinational from current storage:
  - hazard_rs = OR over valid entries of (entry.rd == rs); hazard_rt likewise.
  - An entry being dequeued in the current cycle still counts.
  - Dropped requests never raise a hazard.
- Duplicate rd entries are allowed and drain in order, so the last write wins.

## Timing
- Reset (rst_n low at a clock edge): pointers and count are cleared and all valid bits cleared. Outputs after reset: wb_valid=0, in_ready=1, count=0, hazard_rs=hazard_rt=0, drop_pulse=0, wb_rd=0, wb_data=0.
- Reset mid-operation discards all queued entries. A request presented in the reset cycle is not accepted.
- Latency from accept at edge N to wb_valid high: available after edge N, i.e. one cycle. There is no combinational in-to-wb path.
- Throughput is one accept plus one dequeue per cycle.
- count updates on the edge: +1 on accept-only, -1 on dequeue-only, 0 on both or neither.
- hazard outputs reflect enqueued state after the accepting edge. A request in flight at in_* does not raise a hazard in the same cycle.

## Test plan
- Reset and format check:
  - Reset, then push opcode 42, rd=5, data=0x0000_0000_0000_8001 with wb_ready=1 -> next cycle wb_valid=1, wb_rd=5, wb_data=0xFFFF_FFFF_FFFF_8001.
  - Opcode 34 with data 0xAB_CD -> wb_data=0xCD.
- Fill and stall:
  - wb_ready=0, push 4 entries rd=1..4 -> count=4, in_ready=0.
  - A 5th in_valid is not accepted.
  - wb_ready=1 -> drains rd 1,2,3,4 on consecutive cycles, then count=0 and in_ready=1.
- Simultaneous push/pop:
  - With count=2, hold in_valid=1 and wb_ready=1 for 10 cycles -> count stays 2 and order is preserved.
  - Pointer wrap is exercised.
- Hazard:
  - Queue rd=7 with wb_ready=0, set rs=7, rt=8 -> hazard_rs=1, hazard_rt=0.
  - After the entry drains, hazard_rs=0 the following cycle.
- Drop: push opcode 19 -> drop_pulse=1 for one cycle, count stays 0, no wb_valid.
- Reset mid-stream: reset with 3 entries queued -> count=0, wb_valid=0, and queued data is never written.
